// File: rtl/async_receiver_scard_pkg.sv
// Shared definitions for the smartcard UART: clock default, receiver state
// encodings and the even-parity helper used by both receiver and transmitter.
package async_receiver_scard_pkg;

  localparam int UART_CLK = 40_000_000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    ERRSIG = 3'd5
  } rxState_t;

  function automatic logic evenParity(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/async_receiver_scard_baud_tick_gen.sv
// Fractional baud accumulator: emits a one-clk tick at 16x the line rate.
// The transmitter can reuse it by dividing the tick down to 1x.
module baud_tick_gen
  import async_receiver_scard_pkg::*;
#(
  parameter int ClkFrequency          = UART_CLK,
  parameter int Baud                  = 9600,
  parameter int BaudGeneratorAccWidth = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int    AccW = BaudGeneratorAccWidth;
  localparam longint IncL =
    ((longint'(Baud) << (AccW - 3)) + (longint'(ClkFrequency) >> 8)) /
    (longint'(ClkFrequency) >> 7);
  localparam logic [AccW:0] Inc = (AccW + 1)'(IncL);

  logic [AccW:0] acc;

  // The carry bit is the tick; it is dropped on the following add.
  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else       acc <= {1'b0, acc[AccW-1:0]} + Inc;
  end

  assign tick = acc[AccW];

endmodule

// File: rtl/async_receiver_scard.sv
// ISO 7816-3 T=0 receiver: 16x oversampled 8E1 frames with per-byte error
// flags and an optional error-signal pull-down on parity failure.
module async_receiver_scard
  import async_receiver_scard_pkg::*;
#(
  parameter int ClkFrequency          = UART_CLK,
  parameter int Baud                  = 9600,
  parameter int BaudGeneratorAccWidth = 16,
  parameter bit ErrorSignal           = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_parity_error,
  output logic       RxD_frame_error,
  output logic       RxD_idle,
  output logic       RxD_err_drive
);

  logic       tick;
  logic       rxMeta, rxSync;
  rxState_t   state;
  logic [3:0] osCnt;
  logic [2:0] bitIdx;
  logic [7:0] shiftReg;
  logic       smp7, smp8;
  logic       parErr;
  logic       armed;
  logic       errPhase;
  logic       bitVal;

  baud_tick_gen #(
    .ClkFrequency         (ClkFrequency),
    .Baud                 (Baud),
    .BaudGeneratorAccWidth(BaudGeneratorAccWidth)
  ) uTick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) {rxMeta, rxSync} <= 2'b00;
    else       {rxMeta, rxSync} <= {RxD, rxMeta};
  end

  assign bitVal = majority3(smp7, smp8, rxSync);

  always_ff @(posedge clk) begin
    RxD_data_ready <= 1'b0;
    if (reset) begin
      state            <= IDLE;
      osCnt            <= '0;
      bitIdx           <= '0;
      shiftReg         <= '0;
      smp7             <= 1'b0;
      smp8             <= 1'b0;
      parErr           <= 1'b0;
      armed            <= 1'b0;
      errPhase         <= 1'b0;
      RxD_data         <= '0;
      RxD_parity_error <= 1'b0;
      RxD_frame_error  <= 1'b0;
      RxD_idle         <= 1'b1;
      RxD_err_drive    <= 1'b0;
    end else if (!rx_enable && state != ERRSIG) begin
      state    <= IDLE;
      osCnt    <= '0;
      RxD_idle <= 1'b1;
    end else begin
      if (tick && state != IDLE) begin
        osCnt <= osCnt + 4'd1;
        if (osCnt == 4'd7) smp7 <= rxSync;
        if (osCnt == 4'd8) smp8 <= rxSync;
      end
      case (state)
        IDLE: begin
          // Only a line seen high for a tick may start a frame.
          if (tick && rxSync) armed <= 1'b1;
          if (armed && !rxSync) begin
            state    <= START;
            osCnt    <= '0;
            armed    <= 1'b0;
            RxD_idle <= 1'b0;
          end
        end
        START: if (tick) begin
          if (osCnt == 4'd9 && bitVal) begin
            state    <= IDLE;
            osCnt    <= '0;
            RxD_idle <= 1'b1;
          end else if (osCnt == 4'd15) begin
            state  <= DATA;
            bitIdx <= '0;
          end
        end
        DATA: if (tick) begin
          if (osCnt == 4'd9) shiftReg <= {bitVal, shiftReg[7:1]};
          if (osCnt == 4'd15) begin
            if (bitIdx == 3'd7) state <= PARITY;
            else                bitIdx <= bitIdx + 3'd1;
          end
        end
        PARITY: if (tick) begin
          if (osCnt == 4'd9)  parErr <= bitVal ^ evenParity(shiftReg);
          if (osCnt == 4'd15) state <= STOP;
        end
        STOP: if (tick) begin
          if (osCnt >= 4'd9 && rxSync) armed <= 1'b1;
          if (osCnt == 4'd9) begin
            RxD_data         <= shiftReg;
            RxD_data_ready   <= 1'b1;
            RxD_parity_error <= parErr;
            RxD_frame_error  <= !bitVal;
            if (parErr && ErrorSignal) begin
              state         <= ERRSIG;
              osCnt         <= '0;
              errPhase      <= 1'b0;
              RxD_err_drive <= 1'b1;
            end
          end else if (osCnt == 4'd15) begin
            state    <= IDLE;
            RxD_idle <= 1'b1;
          end
        end
        ERRSIG: if (tick) begin
          // One ETU of pull-down, then one ETU of guard time.
          if (errPhase && rxSync) armed <= 1'b1;
          if (osCnt == 4'd15) begin
            if (!errPhase) begin
              errPhase      <= 1'b1;
              RxD_err_drive <= 1'b0;
            end else begin
              state    <= IDLE;
              RxD_idle <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          osCnt    <= '0;
          RxD_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_async_receiver_scard.sv
// Directed bench for async_receiver_scard: table of frames plus hand-written
// sequences for error signalling, false start, reset, enable and back-to-back.
module tb_async_receiver_scard;

  localparam int CLK_HZ = 1_048_576;
  localparam int BAUD   = 16_384;
  localparam int BIT    = 64;  // clk per bit: tick every 4 clk, 16 ticks per bit

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_enable;
  logic       RxD;
  logic [7:0] data,  neData;
  logic       ready, neReady;
  logic       perr,  nePerr;
  logic       ferr,  neFerr;
  logic       idle,  neIdle;
  logic       drive, neDrive;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  async_receiver_scard #(
    .ClkFrequency(CLK_HZ), .Baud(BAUD), .BaudGeneratorAccWidth(16), .ErrorSignal(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .rx_enable(rx_enable), .RxD(RxD),
    .RxD_data(data), .RxD_data_ready(ready), .RxD_parity_error(perr),
    .RxD_frame_error(ferr), .RxD_idle(idle), .RxD_err_drive(drive)
  );

  async_receiver_scard #(
    .ClkFrequency(CLK_HZ), .Baud(BAUD), .BaudGeneratorAccWidth(16), .ErrorSignal(1'b0)
  ) dutNe (
    .clk(clk), .reset(reset), .rx_enable(rx_enable), .RxD(RxD),
    .RxD_data(neData), .RxD_data_ready(neReady), .RxD_parity_error(nePerr),
    .RxD_frame_error(neFerr), .RxD_idle(neIdle), .RxD_err_drive(neDrive)
  );

  // Output monitor, sampled on the falling edge.
  logic [7:0] strobeLog[$];
  int neStrobes = 0, driveCycles = 0, neDriveCycles = 0, busyCycles = 0;
  int cyc = 0, driveRise = 0, driveFall = 0, idleRise = 0;
  logic prevDrive = 1'b0, prevIdle = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (ready)   strobeLog.push_back(data);
    if (neReady) neStrobes++;
    if (drive)   driveCycles++;
    if (neDrive) neDriveCycles++;
    if (!idle)   busyCycles++;
    if (drive && !prevDrive) driveRise = cyc;
    if (!drive && prevDrive) driveFall = cyc;
    if (idle && !prevIdle)   idleRise = cyc;
    prevDrive = drive;
    prevIdle  = idle;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic sendBit(input logic v);
    RxD = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    sendBit(p);
    sendBit(s);
    RxD = 1'b1;
  endtask

  task automatic idleBits(input int n);
    RxD = 1'b1;
    repeat (n * BIT) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] expData;
    logic       expPerr;
    logic       expFerr;
    int         expDrive;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n0, d0, nd0, ns0, b0;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 0};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0};
    vecs[2] = '{8'h13, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 0};
    vecs[3] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 0};
    vecs[4] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 64};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0};

    reset = 1'b1;
    rx_enable = 1'b1;
    RxD = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_data",  data,  8'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_perr",  perr,  1'b0);
    check("rst_ferr",  ferr,  1'b0);
    check("rst_idle",  idle,  1'b1);
    check("rst_drive", drive, 1'b0);
    idleBits(2);

    for (int v = 0; v < 6; v++) begin
      n0  = strobeLog.size();
      ns0 = neStrobes;
      d0  = driveCycles;
      nd0 = neDriveCycles;
      sendFrame(vecs[v].d, vecs[v].par, vecs[v].stop);
      idleBits(3);
      check($sformatf("v%0d_strobes", v), strobeLog.size() - n0, 1);
      check($sformatf("v%0d_data", v), data, vecs[v].expData);
      check($sformatf("v%0d_perr", v), perr, vecs[v].expPerr);
      check($sformatf("v%0d_ferr", v), ferr, vecs[v].expFerr);
      if (vecs[v].expDrive == 0) checkRange($sformatf("v%0d_drive", v), driveCycles - d0, 0, 0);
      else checkRange($sformatf("v%0d_drive", v), driveCycles - d0, vecs[v].expDrive - 4, vecs[v].expDrive + 4);
      check($sformatf("v%0d_ne_data", v), {neData, 24'd0} | (neStrobes - ns0), {vecs[v].expData, 24'd1});
      checkRange($sformatf("v%0d_ne_drive", v), neDriveCycles - nd0, 0, 0);
    end

    // Parity error with error signal: drive one ETU, idle only after guard.
    n0  = strobeLog.size();
    d0  = driveCycles;
    nd0 = neDriveCycles;
    sendFrame(8'h3C, 1'b1, 1'b1);
    idleBits(4);
    check("pe_strobes", strobeLog.size() - n0, 1);
    check("pe_data", data, 8'h3C);
    check("pe_perr", perr, 1'b1);
    check("pe_ferr", ferr, 1'b0);
    checkRange("pe_drive_len", driveCycles - d0, 60, 68);
    checkRange("pe_guard_to_idle", idleRise - driveFall, 60, 68);
    checkRange("pe_ne_drive", neDriveCycles - nd0, 0, 0);
    check("pe_ne_perr", nePerr, 1'b1);

    // Short glitch is a false start; the following frame still decodes.
    n0 = strobeLog.size();
    RxD = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idleBits(3);
    check("glitch_strobes", strobeLog.size() - n0, 0);
    check("glitch_idle", idle, 1'b1);
    sendFrame(8'h00, 1'b0, 1'b1);
    idleBits(3);
    check("glitch_next_strobes", strobeLog.size() - n0, 1);
    check("glitch_next_data", data, 8'h00);

    // Reset in the middle of data bit 4 of a 0x77 frame.
    n0 = strobeLog.size();
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1 ^ (i == 3));
    RxD = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    #1;
    check("mid_busy", idle, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_idle", idle, 1'b1);
    idleBits(12);
    check("mid_rst_strobes", strobeLog.size() - n0, 0);
    check("mid_rst_data", data, 8'h00);
    sendFrame(8'h5A, 1'b0, 1'b1);
    idleBits(3);
    check("post_rst_strobes", strobeLog.size() - n0, 1);
    check("post_rst_data", data, 8'h5A);

    // Receiver disabled: frame ignored and never leaves IDLE.
    rx_enable = 1'b0;
    n0 = strobeLog.size();
    b0 = busyCycles;
    sendFrame(8'h81, 1'b0, 1'b1);
    idleBits(2);
    check("dis_strobes", strobeLog.size() - n0, 0);
    check("dis_busy", busyCycles - b0, 0);
    rx_enable = 1'b1;
    idleBits(1);

    // Back-to-back frames with only the stop bit between them.
    n0 = strobeLog.size();
    sendFrame(8'h01, 1'b1, 1'b1);
    sendFrame(8'h80, 1'b1, 1'b1);
    idleBits(3);
    check("b2b_strobes", strobeLog.size() - n0, 2);
    if (strobeLog.size() >= n0 + 2) begin
      check("b2b_first", strobeLog[n0], 8'h01);
      check("b2b_second", strobeLog[n0+1], 8'h80);
    end
    check("b2b_perr", perr, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
